// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the core pipeline stage registers.
//   pipe_state_e : skid-buffer stage state (EMPTY / FULL / SKID)
//   RV_NOP       : RISC-V canonical NOP (addi x0,x0,0), typical bubble value
//   fd_payload_t : Fetch->Decode payload {instr, pc, pc_plus4}
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } pipe_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } fd_payload_t;

  localparam int unsigned FD_PAYLOAD_W = $bits(fd_payload_t);

endpackage : pipe_pkg

// File: rtl/pipe_sat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_sat_cnt
// Saturating up-counter used for pipeline stage performance monitoring.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset, clears the count
//   inc_i  : increment request for this cycle
//   cnt_o  : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule : pipe_sat_cnt

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Parametrised pipeline stage register with a 2-entry skid buffer. Both
// ready_o and valid_o come straight from flops, so the downstream ready path
// is cut at this stage. Flush inserts a bubble carrying BUBBLE_VAL.
//
// Optional feature (macro PIPE_STAGE_PERF_CNT_EN): adds saturating stall and
// flush counters (stall_cnt_o, flush_cnt_o), cleared by rst_i only.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   flush_i  : synchronous clear, inserts a bubble
//   valid_i  : upstream payload valid
//   data_i   : upstream payload
//   ready_o  : stage can accept (skid entry empty), registered
//   valid_o  : downstream payload valid, registered
//   data_o   : downstream payload (main entry)
//   ready_i  : downstream accept
//   stall_cnt_o, flush_cnt_o : perf counters (macro only)
// -----------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 96,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  parameter int unsigned       CNT_W      = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ready_i
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              r_valid;
  logic              r_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      // Handshake outputs are decoded from the next state and registered,
      // so neither depends combinationally on ready_i or valid_i.
      r_valid <= (w_state_nxt != ST_EMPTY);
      r_ready <= (w_state_nxt != ST_SKID);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE_VAL;
      w_skid_nxt  = BUBBLE_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (valid_i) begin
            w_main_nxt  = data_i;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (ready_i) begin
            if (valid_i) begin
              w_main_nxt = data_i;
            end else begin
              // data_o keeps its last value while EMPTY
              w_state_nxt = ST_EMPTY;
            end
          end else if (valid_i) begin
            w_skid_nxt  = data_i;
            w_state_nxt = ST_SKID;
          end
        end
        ST_SKID: begin
          // valid_i ignored: ready_o is low, upstream is holding
          if (ready_i) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign data_o  = r_main;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic w_stall;
  assign w_stall = r_valid & ~ready_i;

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
// Directed bench for pipe_stage_skid (DATA_W=32, BUBBLE_VAL=RV_NOP).
// Stimulus pushes each payload it expects to be delivered into a queue; a
// monitor on the falling edge pops and compares on every downstream consume.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ready_i;

  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  logic [DW-1:0] exp_q[$];

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
  logic        sat_inc;
  logic [1:0]  sat_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W     (DW),
    .BUBBLE_VAL (RV_NOP)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .CNT_W      (16)
`endif
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

`ifdef PIPE_STAGE_PERF_CNT_EN
  pipe_sat_cnt #(
    .CNT_W(2)
  ) u_sat2 (
    .clk_i (clk),
    .rst_i (rst_i),
    .inc_i (sat_inc),
    .cnt_o (sat_cnt)
  );
`endif

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a consume happens at the next rising edge.
  always @(negedge clk) begin
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got %h expected none", data_o);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (data_o !== e) begin
          n_bad++;
          $display("FAIL sb_data: got %h expected %h", data_o, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b0;
`ifdef PIPE_STAGE_PERF_CNT_EN
    sat_inc = 1'b0;
`endif
    tick();
    tick();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd1);
    check("rst_data",  data_o, 32'h0000_0013);
    rst_i = 1'b0;
    tick();

    // Streaming: 1 beat/cycle, 1-cycle latency, no gaps
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_i = 1'b1;
      data_i  = DW'(i);
      exp_q.push_back(DW'(i));
      tick();
      check("stream_data",  data_o, DW'(i));
      check("stream_valid", {31'd0, valid_o}, 32'd1);
      check("stream_ready", {31'd0, ready_o}, 32'd1);
    end
    valid_i = 1'b0;
    tick();
    check("drain_valid", {31'd0, valid_o}, 32'd0);
    check("drain_hold",  data_o, 32'd8);

    // Backpressure: A in main, B into skid, C waits for ready_o
    valid_i = 1'b1; data_i = 32'hA1; exp_q.push_back(32'hA1);
    tick();
    ready_i = 1'b0; data_i = 32'hB1; exp_q.push_back(32'hB1);
    tick();
    check("skid_ready", {31'd0, ready_o}, 32'd0);
    check("skid_main",  data_o, 32'hA1);
    ready_i = 1'b1; data_i = 32'hC1;
    tick();
    check("skid_drain_ready", {31'd0, ready_o}, 32'd1);
    check("skid_drain_data",  data_o, 32'hB1);
    exp_q.push_back(32'hC1);
    tick();
    check("bp_c_data", data_o, 32'hC1);
    valid_i = 1'b0;
    tick();

    // Flush while in SKID, with a new beat D presented
    valid_i = 1'b1; data_i = 32'hA2; exp_q.push_back(32'hA2);
    tick();
    ready_i = 1'b0; data_i = 32'hB2; exp_q.push_back(32'hB2);
    tick();
    flush_i = 1'b1; data_i = 32'hD0;
    tick();
    exp_q.delete();
    flush_i = 1'b0; valid_i = 1'b0;
    check("flush_valid", {31'd0, valid_o}, 32'd0);
    check("flush_data",  data_o, 32'h0000_0013);
    check("flush_ready", {31'd0, ready_o}, 32'd1);
    ready_i = 1'b1;
    tick();
    check("flush_no_d", {31'd0, valid_o}, 32'd0);

    // Flush in FULL with simultaneous consume and new input
    valid_i = 1'b1; data_i = 32'hE0; exp_q.push_back(32'hE0);
    tick();
    data_i = 32'hF0; flush_i = 1'b1;
    tick();
    exp_q.delete();
    flush_i = 1'b0; valid_i = 1'b0;
    check("sim_valid", {31'd0, valid_o}, 32'd0);
    check("sim_data",  data_o, 32'h0000_0013);
    check("sim_ready", {31'd0, ready_o}, 32'd1);
    tick();

    // Async reset while SKID holds G/H
    valid_i = 1'b1; data_i = 32'h61; exp_q.push_back(32'h61);
    tick();
    ready_i = 1'b0; data_i = 32'h62; exp_q.push_back(32'h62);
    tick();
    valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_ready", {31'd0, ready_o}, 32'd1);
    check("arst_data",  data_o, 32'h0000_0013);
    exp_q.delete();
    tick();
    rst_i = 1'b0;
    ready_i = 1'b1; valid_i = 1'b1; data_i = 32'hAA; exp_q.push_back(32'hAA);
    tick();
    check("post_rst_data",  data_o, 32'hAA);
    check("post_rst_valid", {31'd0, valid_o}, 32'd1);
    valid_i = 1'b0;
    tick();

`ifdef PIPE_STAGE_PERF_CNT_EN
    // 5 stall cycles then 2 flush cycles
    ready_i = 1'b0; valid_i = 1'b1; data_i = 32'h77; exp_q.push_back(32'h77);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    ready_i = 1'b1;
    tick();
    flush_i = 1'b1;
    tick();
    tick();
    flush_i = 1'b0;
    check("stall_cnt", {16'd0, stall_cnt_o}, 32'd5);
    check("flush_cnt", {16'd0, flush_cnt_o}, 32'd2);
    sat_inc = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    sat_inc = 1'b0;
    check("sat_cnt", {30'd0, sat_cnt}, 32'd3);
`endif

    tick();
    check("sb_empty", DW'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_pipe_stage_skid
